frame_stack: RTL and testbench

Parametrised operand stack with built-in call-frame management for the WebAssembly execution core. It holds operands and locals in one register array and exposes the top NUM_OUT entries in parallel. It addresses locals relative to a frame base and keeps an internal frame-base stack for CALL/RETURN. RETURN compacts result values down to the caller's frame over multiple cycles, signalled by `busy`.

---
 rtl/frame_stack.sv | 231 +++++++++++++++++++++++
 tb/tb_frame_stack.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/frame_stack.sv
// Operand stack with local addressing relative to a frame base and a saved-frame stack.
// RETURN compacts result words to the caller's frame, one word per cycle while busy.
module frame_stack #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 7,
  parameter int unsigned FRAMES_LOG2 = 4,
  parameter int unsigned NUM_OUT     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         data,
  input  logic [DEPTH:0]           count,
  input  logic [DEPTH:0]           offset,
  output logic [NUM_OUT*WIDTH-1:0] out,
  output logic [DEPTH:0]           index,
  output logic [DEPTH:0]           base,
  output logic [FRAMES_LOG2:0]     frame_level,
  output logic                     busy,
  output logic [2:0]               status
);

  localparam int unsigned Max  = 2 ** DEPTH;
  localparam int unsigned FMax = 2 ** FRAMES_LOG2;
  localparam logic [DEPTH:0]       MaxIdx  = {1'b1, {DEPTH{1'b0}}};
  localparam logic [FRAMES_LOG2:0] FMaxLvl = {1'b1, {FRAMES_LOG2{1'b0}}};
  localparam logic [DEPTH:0]       One     = 1;
  localparam logic [FRAMES_LOG2:0] LvlOne  = 1;

  typedef enum logic [2:0] {
    OpNop, OpPush, OpPop, OpReplace, OpLocalGet, OpLocalSet, OpCall, OpReturn
  } op_e;

  typedef enum logic [2:0] {
    StatNone, StatEmpty, StatFull, StatUnderflow, StatOverflow, StatBadOffset,
    StatFrameOverflow, StatReserved
  } status_e;

  typedef enum logic [0:0] {StIdle, StCopy} state_e;

  logic [WIDTH-1:0] mem    [Max];
  logic [DEPTH:0]   frames [FMax];

  state_e                 state_q, state_d;
  status_e                status_q, status_d, err;
  logic [DEPTH:0]         index_q, index_d, base_q, base_d, avail;
  logic [DEPTH:0]         ret_cnt_q, ret_cnt_d, ret_i_q, ret_i_d;
  logic [DEPTH-1:0]       ret_src_q, ret_src_d, local_addr;
  logic [FRAMES_LOG2:0]   level_q, level_d;
  logic [FRAMES_LOG2-1:0] lvl_top;
  logic                   is_err, defer, mem_we, frame_we;
  logic [DEPTH-1:0]       mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;

  function automatic status_e stat_of(input logic [DEPTH:0] idx, input logic [DEPTH:0] bs);
    if (idx == MaxIdx) return StatFull;
    if (idx == bs) return StatEmpty;
    return StatNone;
  endfunction

  assign avail      = index_q - base_q;
  assign local_addr = base_q[DEPTH-1:0] + offset[DEPTH-1:0];
  assign lvl_top    = level_q[FRAMES_LOG2-1:0] - FRAMES_LOG2'(1);

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    index_d   = index_q;
    base_d    = base_q;
    level_d   = level_q;
    ret_cnt_d = ret_cnt_q;
    ret_i_d   = ret_i_q;
    ret_src_d = ret_src_q;
    err       = StatNone;
    is_err    = 1'b0;
    defer     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    frame_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          unique case (op_e'(op))
            OpNop: ;
            OpPush: begin
              if (index_q == MaxIdx) begin
                is_err = 1'b1;
                err    = StatOverflow;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = index_q[DEPTH-1:0];
                mem_wdata = data;
                index_d   = index_q + One;
              end
            end
            OpPop: begin
              if (count > avail) begin
                is_err = 1'b1;
                err    = StatUnderflow;
              end else begin
                index_d = index_q - count;
              end
            end
            OpReplace: begin
              if (avail == '0) begin
                is_err = 1'b1;
                err    = StatUnderflow;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = index_q[DEPTH-1:0] - DEPTH'(1);
                mem_wdata = data;
              end
            end
            OpLocalGet: begin
              if (offset >= avail) begin
                is_err = 1'b1;
                err    = StatBadOffset;
              end else if (index_q == MaxIdx) begin
                is_err = 1'b1;
                err    = StatOverflow;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = index_q[DEPTH-1:0];
                mem_wdata = mem[local_addr];
                index_d   = index_q + One;
              end
            end
            OpLocalSet: begin
              if (offset >= avail) begin
                is_err = 1'b1;
                err    = StatBadOffset;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = local_addr;
                mem_wdata = data;
              end
            end
            OpCall: begin
              if (count > avail) begin
                is_err = 1'b1;
                err    = StatUnderflow;
              end else if (level_q == FMaxLvl) begin
                is_err = 1'b1;
                err    = StatFrameOverflow;
              end else begin
                frame_we = 1'b1;
                base_d   = index_q - count;
                level_d  = level_q + LvlOne;
              end
            end
            OpReturn: begin
              if (level_q == '0 || count > avail) begin
                is_err = 1'b1;
                err    = StatUnderflow;
              end else if (count == '0) begin
                index_d = base_q;
                base_d  = frames[lvl_top];
                level_d = level_q - LvlOne;
              end else begin
                // Status is settled on the last copy cycle, not at acceptance.
                defer     = 1'b1;
                state_d   = StCopy;
                ret_cnt_d = count;
                ret_i_d   = '0;
                ret_src_d = index_q[DEPTH-1:0] - count[DEPTH-1:0];
              end
            end
          endcase
          if (is_err) status_d = err;
          else if (!defer) status_d = stat_of(index_d, base_d);
        end
      end
      StCopy: begin
        // Ascending copy is overlap-safe since the destination never passes the source.
        mem_we    = 1'b1;
        mem_waddr = base_q[DEPTH-1:0] + ret_i_q[DEPTH-1:0];
        mem_wdata = mem[ret_src_q + ret_i_q[DEPTH-1:0]];
        ret_i_d   = ret_i_q + One;
        if (ret_i_q == ret_cnt_q - One) begin
          index_d  = base_q + ret_cnt_q;
          base_d   = frames[lvl_top];
          level_d  = level_q - LvlOne;
          state_d  = StIdle;
          status_d = stat_of(index_d, base_d);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      status_q  <= StatEmpty;
      index_q   <= '0;
      base_q    <= '0;
      level_q   <= '0;
      ret_cnt_q <= '0;
      ret_i_q   <= '0;
      ret_src_q <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      index_q   <= index_d;
      base_q    <= base_d;
      level_q   <= level_d;
      ret_cnt_q <= ret_cnt_d;
      ret_i_q   <= ret_i_d;
      ret_src_q <= ret_src_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    if (frame_we && !reset) frames[level_q[FRAMES_LOG2-1:0]] <= base_q;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic [DEPTH-1:0] rd_addr;
    assign rd_addr = index_q[DEPTH-1:0] - DEPTH'(k + 1);
    assign out[k*WIDTH +: WIDTH] = (index_q > (DEPTH+1)'(k)) ? mem[rd_addr] : '0;
  end

  assign index       = index_q;
  assign base        = base_q;
  assign frame_level = level_q;
  assign busy        = (state_q == StCopy);
  assign status      = status_q;

endmodule

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack: stack ops, locals, CALL/RETURN compaction, limits, reset abort.
module tb_frame_stack;

  localparam logic [2:0] OpNop = 3'd0, OpPush = 3'd1, OpPop = 3'd2, OpReplace = 3'd3;
  localparam logic [2:0] OpLget = 3'd4, OpLset = 3'd5, OpCall = 3'd6, OpRet = 3'd7;
  localparam logic [2:0] SNone = 3'd0, SEmpty = 3'd1, SFull = 3'd2, SUnder = 3'd3;
  localparam logic [2:0] SOver = 3'd4, SBadOff = 3'd5, SFrameOver = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] data = '0;
  logic [7:0]  count = '0;
  logic [7:0]  offset = '0;
  logic [95:0] out;
  logic [7:0]  index;
  logic [7:0]  base;
  logic [4:0]  frame_level;
  logic        busy;
  logic [2:0]  status;

  int checks = 0;
  int failures = 0;

  frame_stack dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .data        (data),
    .count       (count),
    .offset      (offset),
    .out         (out),
    .index       (index),
    .base        (base),
    .frame_level (frame_level),
    .busy        (busy),
    .status      (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return out[k*32 +: 32];
  endfunction

  task automatic apply(input logic [2:0] o, input logic [31:0] d, input logic [7:0] c,
                       input logic [7:0] f);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    data     = d;
    count    = c;
    offset   = f;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_index", index, 0);
    check("rst_base", base, 0);
    check("rst_level", frame_level, 0);
    check("rst_busy", busy, 0);
    check("rst_status", status, SEmpty);
    check("rst_out", out, 0);

    apply(OpPush, 32'h11, 0, 0);
    check("push1_word0", word(0), 32'h11);
    check("push1_word1", word(1), 32'h0);
    apply(OpPush, 32'h22, 0, 0);
    apply(OpPush, 32'h33, 0, 0);
    check("push3_index", index, 3);
    check("push3_out", out, {32'h11, 32'h22, 32'h33});
    check("push3_status", status, SNone);
    apply(OpReplace, 32'h44, 0, 0);
    check("replace_out", out, {32'h11, 32'h22, 32'h44});
    apply(OpPop, 0, 3, 0);
    check("pop3_index", index, 0);
    check("pop3_status", status, SEmpty);
    check("pop3_out", out, 0);
    apply(OpReplace, 32'h55, 0, 0);
    check("replace_empty", status, SUnder);
    apply(OpNop, 0, 0, 0);
    check("nop_refresh", status, SEmpty);

    for (int i = 0; i < 128; i++) apply(OpPush, 32'(i), 0, 0);
    check("fill_index", index, 128);
    check("fill_status", status, SFull);
    check("fill_word0", word(0), 127);
    apply(OpPush, 32'hFF, 0, 0);
    check("ovf_status", status, SOver);
    check("ovf_index", index, 128);
    check("ovf_word0", word(0), 127);
    apply(OpLget, 0, 0, 0);
    check("lget_ovf", status, SOver);
    apply(OpPop, 0, 128, 0);
    check("drain_index", index, 0);

    for (int i = 1; i <= 5; i++) apply(OpPush, 32'hA0 + 32'(i), 0, 0);
    apply(OpCall, 0, 2, 0);
    check("call_base", base, 3);
    check("call_level", frame_level, 1);
    check("call_status", status, SNone);
    apply(OpLset, 32'hEE, 0, 2);
    check("lset_bad", status, SBadOff);
    check("lset_bad_word0", word(0), 32'hA5);
    apply(OpLget, 0, 0, 1);
    check("lget_index", index, 6);
    check("lget_word0", word(0), 32'hA5);
    apply(OpPop, 0, 4, 0);
    check("pop_under", status, SUnder);
    check("pop_under_index", index, 6);
    apply(OpPush, 32'hB6, 0, 0);
    apply(OpPush, 32'hB7, 0, 0);
    apply(OpPush, 32'hB8, 0, 0);
    check("pre_ret_index", index, 9);

    // RETURN count=2, with a PUSH held on op_valid while busy.
    @(negedge clk);
    op_valid = 1'b1;
    op       = OpRet;
    count    = 2;
    @(posedge clk);
    #1;
    check("ret_busy0", busy, 1);
    op   = OpPush;
    data = 32'hDEAD;
    @(posedge clk);
    #1;
    check("ret_busy1", busy, 1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("ret_busy_end", busy, 0);
    check("ret_index", index, 5);
    check("ret_base", base, 0);
    check("ret_level", frame_level, 0);
    check("ret_out", out, {32'hA3, 32'hB7, 32'hB8});
    check("ret_status", status, SNone);

    apply(OpRet, 0, 0, 0);
    check("ret_lvl0", status, SUnder);
    for (int i = 0; i < 16; i++) apply(OpCall, 0, 0, 0);
    check("nest_level", frame_level, 16);
    check("nest_base", base, 5);
    check("nest_status", status, SEmpty);
    apply(OpCall, 0, 0, 0);
    check("frame_ovf", status, SFrameOver);
    check("frame_ovf_level", frame_level, 16);
    apply(OpRet, 0, 0, 0);
    check("ret0_level", frame_level, 15);
    check("ret0_busy", busy, 0);
    for (int i = 0; i < 15; i++) apply(OpRet, 0, 0, 0);
    check("unwind_level", frame_level, 0);
    check("unwind_base", base, 0);
    check("unwind_index", index, 5);

    apply(OpCall, 0, 4, 0);
    check("call4_base", base, 1);
    @(negedge clk);
    op_valid = 1'b1;
    op       = OpRet;
    count    = 4;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("ret4_busy", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_index", index, 0);
    check("abort_base", base, 0);
    check("abort_busy", busy, 0);
    check("abort_level", frame_level, 0);
    check("abort_status", status, SEmpty);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
